// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 sequence controller: locks the session, classifies each packet header against the
// expected sequence number, gates extracted message beats and raises retransmit requests.
module mold_seq_ctrl #(
   parameter int SID_W = 80,
   parameter int SEQ_W = 64,
   parameter int ML_W  = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             hdr_v_i,
   input  logic [SID_W-1:0] hdr_sid_i,
   input  logic [SEQ_W-1:0] hdr_seq_i,
   input  logic [ML_W-1:0]  hdr_cnt_i,
   input  logic             msg_v_i,
   input  logic             msg_start_i,
   input  logic             pkt_end_i,
   output logic             msg_keep_o,
   output logic             gap_v_o,
   output logic [SEQ_W-1:0] gap_seq_o,
   output logic [ML_W-1:0]  gap_cnt_o,
   input  logic             gap_ready_i,
   output logic             gap_lost_o,
   output logic             sid_err_o,
   output logic             eos_o,
   output logic [SEQ_W-1:0] expected_seq_o
);

   localparam logic [1:0] WAIT_HDR = 2'd0;
   localparam logic [1:0] FWD      = 2'd1;
   localparam logic [1:0] DROP     = 2'd2;
   localparam logic [1:0] END      = 2'd3;

   localparam logic [ML_W-1:0]  CNT_EOS = {ML_W{1'b1}};
   localparam logic [ML_W-1:0]  CNT_SAT = {{(ML_W-1){1'b1}}, 1'b0};
   localparam logic [SEQ_W-1:0] SAT_EXT = {{(SEQ_W-ML_W){1'b0}}, CNT_SAT};

   logic [1:0]       state_q, hdr_state, state_d;
   logic             locked_q, keep_q;
   logic [SID_W-1:0] sid_q;
   logic [SEQ_W-1:0] exp_q, exp_d;
   logic [ML_W-1:0]  skip_q, skip_d;

   logic [SEQ_W-1:0] cnt_ext, ref_seq, seq_end, diff_fwd, diff_back;
   logic [ML_W-1:0]  gap_cnt_d;
   logic             sid_ok, hdr_act, new_gap, sid_err_d, eos_d;
   logic             start_beat, keep_now, gap_acc;

   // Before lock the header itself defines the reference, so the first packet is always in order.
   always_comb begin
      cnt_ext   = {{(SEQ_W-ML_W){1'b0}}, hdr_cnt_i};
      ref_seq   = locked_q ? exp_q : hdr_seq_i;
      sid_ok    = !locked_q || (hdr_sid_i == sid_q);
      seq_end   = hdr_seq_i + cnt_ext;
      diff_fwd  = hdr_seq_i - ref_seq;
      diff_back = ref_seq - hdr_seq_i;
      gap_cnt_d = (diff_fwd > SAT_EXT) ? CNT_SAT : diff_fwd[ML_W-1:0];
      hdr_act   = hdr_v_i && (state_q != END);
   end

   always_comb begin
      hdr_state = state_q;
      exp_d     = exp_q;
      skip_d    = skip_q;
      new_gap   = 1'b0;
      sid_err_d = 1'b0;
      eos_d     = 1'b0;
      if (hdr_act) begin
         exp_d  = ref_seq;
         skip_d = '0;
         if (!sid_ok) begin
            sid_err_d = 1'b1;
            hdr_state = DROP;
         end else if (hdr_cnt_i == CNT_EOS) begin
            eos_d     = 1'b1;
            hdr_state = END;
         end else if (hdr_seq_i == ref_seq) begin
            hdr_state = FWD;
            exp_d     = seq_end;
         end else if (hdr_seq_i > ref_seq) begin
            new_gap   = 1'b1;
            hdr_state = FWD;
            exp_d     = seq_end;
         end else if (seq_end <= ref_seq) begin
            hdr_state = DROP;
         end else begin
            hdr_state = FWD;
            skip_d    = diff_back[ML_W-1:0];
            exp_d     = seq_end;
         end
      end
      state_d = hdr_state;
      if (pkt_end_i && (hdr_state == FWD || hdr_state == DROP))
         state_d = WAIT_HDR;
   end

   always_comb begin
      start_beat = msg_v_i && msg_start_i;
      keep_now   = start_beat ? (skip_q == '0) : keep_q;
      msg_keep_o = (state_q == FWD) && msg_v_i && keep_now;
      gap_acc    = gap_v_o && gap_ready_i;
   end

   assign expected_seq_o = exp_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= WAIT_HDR;
         locked_q   <= 1'b0;
         sid_q      <= '0;
         exp_q      <= '0;
         skip_q     <= '0;
         keep_q     <= 1'b0;
         gap_v_o    <= 1'b0;
         gap_seq_o  <= '0;
         gap_cnt_o  <= '0;
         gap_lost_o <= 1'b0;
         sid_err_o  <= 1'b0;
         eos_o      <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         sid_err_o <= sid_err_d;
         eos_o     <= eos_o | eos_d;
         if (hdr_act && !locked_q) begin
            locked_q <= 1'b1;
            sid_q    <= hdr_sid_i;
         end
         if (hdr_act) begin
            skip_q <= skip_d;
            keep_q <= 1'b0;
         end else if (state_q == FWD && start_beat) begin
            keep_q <= (skip_q == '0);
            if (skip_q != '0)
               skip_q <= skip_q - 1'b1;
         end
         // A pending request wins over a new gap unless it is being accepted this cycle.
         gap_lost_o <= new_gap && gap_v_o && !gap_ready_i;
         if (new_gap && (!gap_v_o || gap_ready_i)) begin
            gap_v_o   <= 1'b1;
            gap_seq_o <= ref_seq;
            gap_cnt_o <= gap_cnt_d;
         end else if (gap_acc) begin
            gap_v_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Directed bench for mold_seq_ctrl: packet-level reference model checked every cycle plus literal pins.
module tb_mold_seq_ctrl;

   logic        clk = 1'b0;
   logic        nreset;
   logic        hdr_v;
   logic [79:0] hdr_sid;
   logic [63:0] hdr_seq;
   logic [15:0] hdr_cnt;
   logic        msg_v, msg_start, pkt_end;
   logic        msg_keep;
   logic        gap_v;
   logic [63:0] gap_seq;
   logic [15:0] gap_cnt;
   logic        gap_ready;
   logic        gap_lost, sid_err, eos;
   logic [63:0] expected_seq;

   mold_seq_ctrl dut (
      .clk(clk), .nreset(nreset),
      .hdr_v_i(hdr_v), .hdr_sid_i(hdr_sid), .hdr_seq_i(hdr_seq), .hdr_cnt_i(hdr_cnt),
      .msg_v_i(msg_v), .msg_start_i(msg_start), .pkt_end_i(pkt_end),
      .msg_keep_o(msg_keep),
      .gap_v_o(gap_v), .gap_seq_o(gap_seq), .gap_cnt_o(gap_cnt), .gap_ready_i(gap_ready),
      .gap_lost_o(gap_lost), .sid_err_o(sid_err), .eos_o(eos), .expected_seq_o(expected_seq)
   );

   always #5 clk = ~clk;

   localparam logic [79:0] SID_A = 80'h4142_4344_4546_4748_494A;
   localparam logic [79:0] SID_B = 80'h5152_5354_5556_5758_595A;

   int pass_cnt = 0;
   int total_cnt = 0;
   int kept = 0;
   int dropped = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: packet mode, messages started in this packet, how many to skip, one pending gap.
   localparam int M_IDLE = 0, M_FWD = 1, M_DROP = 2, M_END = 3;
   int          m_mode;
   logic        m_locked, m_cur_keep, m_eos, m_sid_err, m_lost, m_gap_pend;
   logic [79:0] m_sid;
   logic [63:0] m_exp, m_skip, m_started, m_gap_seq;
   logic [15:0] m_gap_cnt;
   logic        k_exp;

   task automatic m_reset();
      m_mode = M_IDLE; m_locked = 0; m_cur_keep = 0; m_eos = 0; m_sid_err = 0; m_lost = 0;
      m_gap_pend = 0; m_sid = '0; m_exp = '0; m_skip = '0; m_started = '0;
      m_gap_seq = '0; m_gap_cnt = '0;
   endtask

   task automatic m_step();
      logic [63:0] last, diff, gs;
      logic [15:0] gc;
      logic        accepted, gap_new;
      m_sid_err = 0;
      m_lost    = 0;
      gap_new   = 0;
      gs        = '0;
      gc        = '0;
      accepted  = m_gap_pend && gap_ready;
      if (hdr_v && m_mode != M_END) begin
         if (!m_locked) begin
            m_locked = 1; m_sid = hdr_sid; m_exp = hdr_seq;
         end
         m_started = 0; m_cur_keep = 0; m_skip = 0;
         last = hdr_seq + 64'(hdr_cnt);
         if (hdr_sid != m_sid) begin
            m_sid_err = 1; m_mode = M_DROP;
         end else if (hdr_cnt == 16'hFFFF) begin
            m_eos = 1; m_mode = M_END;
         end else if (hdr_seq >= m_exp) begin
            if (hdr_seq > m_exp) begin
               gap_new = 1;
               gs = m_exp;
               diff = hdr_seq - m_exp;
               gc = (diff > 64'hFFFE) ? 16'hFFFE : 16'(diff);
            end
            m_mode = M_FWD; m_exp = last;
         end else if (last <= m_exp) begin
            m_mode = M_DROP;
         end else begin
            m_skip = m_exp - hdr_seq; m_mode = M_FWD; m_exp = last;
         end
      end else if (m_mode == M_FWD && msg_v && msg_start) begin
         m_cur_keep = (m_started >= m_skip);
         m_started++;
      end
      if (pkt_end && (m_mode == M_FWD || m_mode == M_DROP)) m_mode = M_IDLE;
      if (gap_new) begin
         if (m_gap_pend && !accepted) m_lost = 1;
         else begin
            m_gap_pend = 1; m_gap_seq = gs; m_gap_cnt = gc;
         end
      end else if (accepted) begin
         m_gap_pend = 0;
      end
   endtask

   initial m_reset();

   always @(negedge clk) begin
      if (!nreset) begin
         m_reset();
      end else begin
         k_exp = (m_mode == M_FWD) && msg_v && (msg_start ? (m_started >= m_skip) : m_cur_keep);
         chk("keep", 64'(msg_keep), 64'(k_exp));
         chk("expected_seq", expected_seq, m_exp);
         chk("gap_v", 64'(gap_v), 64'(m_gap_pend));
         if (m_gap_pend) begin
            chk("gap_seq", gap_seq, m_gap_seq);
            chk("gap_cnt", 64'(gap_cnt), 64'(m_gap_cnt));
         end
         chk("sid_err", 64'(sid_err), 64'(m_sid_err));
         chk("gap_lost", 64'(gap_lost), 64'(m_lost));
         chk("eos", 64'(eos), 64'(m_eos));
         if (msg_v && msg_start) begin
            if (msg_keep) kept++;
            else dropped++;
         end
         m_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hdr(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c, input logic e);
      hdr_v = 1; hdr_sid = s; hdr_seq = q; hdr_cnt = c; pkt_end = e;
      tick();
      hdr_v = 0; pkt_end = 0;
   endtask

   task automatic msgs(input int n, input logic e);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 2; b++) begin
            msg_v = 1; msg_start = (b == 0); pkt_end = e && (i == n - 1) && (b == 1);
            tick();
         end
      end
      msg_v = 0; msg_start = 0; pkt_end = 0;
   endtask

   int kept_snap;

   initial begin
      nreset = 0; hdr_v = 0; hdr_sid = '0; hdr_seq = '0; hdr_cnt = '0;
      msg_v = 0; msg_start = 0; pkt_end = 0; gap_ready = 0;
      tick(); tick();
      chk("rst_keep", 64'(msg_keep), 0);
      chk("rst_gap_v", 64'(gap_v), 0);
      chk("rst_gap_seq", gap_seq, 0);
      chk("rst_gap_cnt", 64'(gap_cnt), 0);
      chk("rst_expected", expected_seq, 0);
      chk("rst_flags", {61'd0, eos, sid_err, gap_lost}, 0);
      nreset = 1;
      tick();

      // In-order packets
      hdr(SID_A, 64'd1, 16'd3, 0); msgs(3, 1);
      hdr(SID_A, 64'd4, 16'd2, 0); msgs(2, 1);
      chk("inorder_expected", expected_seq, 64'd6);
      chk("inorder_kept", 64'(kept), 64'd5);
      chk("inorder_no_gap", 64'(gap_v), 0);

      // Gap, held for several cycles without ready
      hdr(SID_A, 64'd10, 16'd2, 0);
      chk("gap_v", 64'(gap_v), 1);
      chk("gap_seq", gap_seq, 64'd6);
      chk("gap_cnt", 64'(gap_cnt), 64'd4);
      chk("gap_expected", expected_seq, 64'd12);
      msgs(2, 1);
      repeat (5) tick();
      chk("gap_hold_seq", gap_seq, 64'd6);
      chk("gap_hold_cnt", 64'(gap_cnt), 64'd4);
      chk("gap_kept", 64'(kept), 64'd7);
      gap_ready = 1; tick(); gap_ready = 0;
      chk("gap_accepted", 64'(gap_v), 0);

      // Duplicate then partial overlap
      hdr(SID_A, 64'd8, 16'd3, 0); msgs(3, 1);
      chk("dup_expected", expected_seq, 64'd12);
      chk("dup_dropped", 64'(dropped), 64'd3);
      hdr(SID_A, 64'd10, 16'd4, 0); msgs(4, 1);
      chk("ovl_expected", expected_seq, 64'd14);
      chk("ovl_kept", 64'(kept), 64'd9);
      chk("ovl_dropped", 64'(dropped), 64'd5);

      // Foreign session
      hdr(SID_B, 64'd14, 16'd2, 0);
      chk("sid_err_pulse", 64'(sid_err), 1);
      msgs(2, 1);
      chk("sid_err_clear", 64'(sid_err), 0);
      chk("sid_expected", expected_seq, 64'd14);
      chk("sid_dropped", 64'(dropped), 64'd7);

      // Lost gap while pending, then accept and load in the same cycle
      hdr(SID_A, 64'd20, 16'd1, 0); msgs(1, 1);
      hdr(SID_A, 64'd30, 16'd1, 0);
      chk("lost_pulse", 64'(gap_lost), 1);
      chk("lost_keep_seq", gap_seq, 64'd14);
      chk("lost_keep_cnt", 64'(gap_cnt), 64'd6);
      chk("lost_expected", expected_seq, 64'd31);
      msgs(1, 1);
      gap_ready = 1;
      hdr(SID_A, 64'd40, 16'd2, 0);
      chk("reload_no_loss", 64'(gap_lost), 0);
      chk("reload_seq", gap_seq, 64'd31);
      chk("reload_cnt", 64'(gap_cnt), 64'd9);
      msgs(2, 1);

      // Heartbeat with tlast in the header cycle, then saturated gap
      hdr(SID_A, 64'd50, 16'd0, 1);
      chk("hb_gap_seq", gap_seq, 64'd42);
      chk("hb_gap_cnt", 64'(gap_cnt), 64'd8);
      chk("hb_expected", expected_seq, 64'd50);
      hdr(SID_A, 64'h20000, 16'd1, 0);
      chk("sat_gap_cnt", 64'(gap_cnt), 64'hFFFE);
      chk("sat_gap_seq", gap_seq, 64'd50);
      msgs(1, 1);

      // Header without prior tlast restarts packet state
      hdr(SID_A, 64'h20001, 16'd3, 0); msgs(1, 0);
      hdr(SID_A, 64'h20004, 16'd1, 0); msgs(1, 1);
      chk("notlast_expected", expected_seq, 64'h20005);

      // End of session
      hdr(SID_A, 64'h20005, 16'hFFFF, 0);
      chk("eos_set", 64'(eos), 1);
      kept_snap = kept;
      hdr(SID_A, 64'h20005, 16'd2, 0); msgs(2, 1);
      chk("eos_expected", expected_seq, 64'h20005);
      chk("eos_no_keep", 64'(kept), 64'(kept_snap));
      chk("eos_sticky", 64'(eos), 1);

      // Reset clears the session; reset again mid-message
      gap_ready = 0;
      nreset = 0; tick();
      chk("rst2_eos", 64'(eos), 0);
      nreset = 1; tick();
      hdr(SID_B, 64'd100, 16'd2, 0);
      msg_v = 1; msg_start = 1;
      #1;
      chk("mid_keep_before", 64'(msg_keep), 1);
      chk("mid_expected_before", expected_seq, 64'd102);
      nreset = 0;
      #1;
      chk("mid_rst_keep", 64'(msg_keep), 0);
      chk("mid_rst_expected", expected_seq, 0);
      chk("mid_rst_flags", {60'd0, gap_v, eos, sid_err, gap_lost}, 0);
      msg_v = 0; msg_start = 0;
      tick();
      nreset = 1; tick();
      hdr(SID_A, 64'd5, 16'd1, 0);
      chk("relock_expected", expected_seq, 64'd6);
      chk("relock_no_sid_err", 64'(sid_err), 0);
      msgs(1, 1);
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mold_seq_ctrl.md
# mold_seq_ctrl

MoldUDP64 sequence controller sitting after the header decoder and message extractor. Per packet it locks the session, compares the header sequence number against the expected next sequence number, and gates each extracted message as forwarded or dropped (duplicates, foreign session). It raises a retransmit (gap) request through a valid/ready handshake and detects end-of-session.

## Interface
- `SID_W`, 80: session ID width (10 bytes).
- `SEQ_W`, 64: sequence number width.
- `ML_W`, 16: message count width.
- `clk` in 1: clock.
- `nreset` in 1: asynchronous active-low reset.
- `hdr_v_i` in 1: one-cycle pulse; header fields valid.
- `hdr_sid_i` in SID_W: session ID.
- `hdr_seq_i` in SEQ_W: sequence number of first message in packet.
- `hdr_cnt_i` in ML_W: message count.
  - 0 = heartbeat.
  - 16'hFFFF = end of session.
- `msg_v_i` in 1: message beat valid, from extractor.
- `msg_start_i` in 1: first beat of a message; qualified by `msg_v_i`.
- `pkt_end_i` in 1: last beat of UDP packet (tlast & tvalid).
- `msg_keep_o` out 1: current beat is forwarded; combinational, aligned with `msg_v_i`.
- `gap_v_o` out 1: retransmit request valid.
- `gap_seq_o` out SEQ_W: first missing sequence number.
- `gap_cnt_o` out ML_W: number of missing messages, saturated at 16'hFFFE.
- `gap_ready_i` in 1: retransmit requester accepts.
- `gap_lost_o` out 1: pulse; gap detected while request pending, new gap discarded.
- `sid_err_o` out 1: pulse; header session differs from locked session.
- `eos_o` out 1: sticky; end-of-session received.
- `expected_seq_o` out SEQ_W: next expected sequence number.

## Operation
- States:
  - WAIT_HDR: between packets.
  - FWD: packet accepted, gating messages.
  - DROP: whole packet discarded.
  - END: session over.
- Locking: `locked_q` is 0 after reset. The first header while unlocked latches `hdr_sid_i`, sets expected = `hdr_seq_i`, and sets `locked_q`.
- Header decision on `hdr_v_i`, locked, in WAIT_HDR/FWD/DROP:
  - SID mismatch: `sid_err_o` pulse, go to DROP, expected unchanged.
  - cnt = FFFF: set `eos_o`, go to END.
  - seq == expected: go to FWD, skip = 0, expected += cnt.
  - seq > expected: issue gap (seq = expected, cnt = min(seq−expected, FFFE)), go to FWD, skip = 0, expected = seq + cnt.
  - seq < expected and seq + cnt <= expected: duplicate, go to DROP, expected unchanged.
  - seq < expected and seq + cnt > expected: partial overlap, go to FWD, skip = expected − seq, expected = seq + cnt.
  - cnt = 0 (heartbeat): same rules; FWD with no messages.
- Arithmetic:
  - All sequence math is unsigned modulo 2^SEQ_W.
  - Comparisons are plain unsigned; wrap-around is not treated as ordered.
  - `hdr_cnt_i` is zero-extended to SEQ_W.
- Message gating:
  - On `msg_v_i & msg_start_i` in FWD: keep = (skip_q == 0), latched into `keep_q`, and skip_q decrements if nonzero.
  - Non-start beats use `keep_q`.
  - `msg_keep_o` = FWD & `msg_v_i` & keep.
  - In WAIT_HDR/DROP/END, `msg_keep_o` = 0.
- Packet end: `pkt_end_i` in FWD/DROP returns to WAIT_HDR after that cycle's beat is gated. It is ignored in WAIT_HDR and END.
- Header while in FWD/DROP (missing tlast): treated as a new packet and evaluated normally. Remaining skip/keep state is discarded.
- END is left only by reset. Headers are ignored and `msg_keep_o` stays 0.
- Gap handshake:
  - `gap_v_o` is held with stable `gap_seq_o`/`gap_cnt_o` until `gap_v_o & gap_ready_i`.
  - A new gap while pending pulses `gap_lost_o`; the pending request is kept.
  - A new gap in the same cycle as acceptance is loaded, with no loss.

## Timing
- Reset values:
  - State WAIT_HDR; `locked_q` 0; expected 0; skip 0; `keep_q` 0.
  - `gap_v_o` 0, `gap_seq_o` 0, `gap_cnt_o` 0.
  - `gap_lost_o` 0, `sid_err_o` 0, `eos_o` 0, `msg_keep_o` 0.
- Header to state: `hdr_v_i` at cycle N updates state, expected, skip and gap registers at edge N+1.
  - `expected_seq_o`, `sid_err_o` and `gap_v_o` are visible in cycle N+1.
- The extractor never presents `msg_start_i` before cycle N+1. The first message beat is gated with the new state.
- `msg_keep_o`: zero-cycle latency from `msg_v_i`.
- `hdr_v_i` and `pkt_end_i` in the same cycle: the header is evaluated and the state goes to WAIT_HDR afterwards.
  - This is a heartbeat-only packet; the gap is still issued.
- Reset mid-packet: everything returns to reset values asynchronously. The session must re-lock.

## Test plan
- In-order: lock sid A, seq 1 cnt 3, then seq 4 cnt 2 → all 5 messages keep=1, `expected_seq_o` = 6, no gap.
- Gap: expected 6, header seq 10 cnt 2 → `gap_v_o` with seq 6 cnt 4, both messages kept, expected 12.
  - Hold `gap_ready_i` = 0 for 5 cycles → outputs stable.
- Duplicate and overlap:
  - expected 12, seq 8 cnt 3 → DROP, all keep=0, expected 12.
  - seq 10 cnt 4 → first 2 messages dropped, last 2 kept, expected 14.
- Foreign session: sid B header → `sid_err_o` one-cycle pulse, packet dropped, expected unchanged.
- Gap lost: pending gap not accepted, second gap header → `gap_lost_o` pulse, original seq/cnt retained.
  - Accept + new gap in same cycle → new values loaded, no pulse.
- End/reset:
  - cnt FFFF → `eos_o` = 1, later in-order header ignored.
  - Assert `nreset` mid-message → all outputs 0 immediately; next header re-locks.
